// File: rtl/qadd_pkg.sv
// Shared defaults, sequencer states and sign-magnitude helpers for the qadd accumulator.
// Helpers work on 64-bit words with an explicit width so any N up to 64 can use them.
package qadd_pkg;

  localparam int QADD_N = 32;
  localparam int QADD_Q = 15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Largest representable magnitude with the requested sign, in an n-bit word.
  function automatic logic [63:0] sm_sat(input logic sign, input int unsigned n);
    logic [63:0] w;
    w        = (64'd1 << (n - 1)) - 64'd1;
    w[n - 1] = sign;
    return w;
  endfunction

  // Collapse -0 onto +0 so downstream stages only ever see one zero encoding.
  function automatic logic [63:0] sm_norm(input logic [63:0] x, input int unsigned n);
    logic [63:0] mag_mask;
    mag_mask = (64'd1 << (n - 1)) - 64'd1;
    return ((x & mag_mask) == 64'd0) ? 64'd0 : x;
  endfunction

endpackage

// File: rtl/qadd.sv
// Combinational sign-magnitude adder: c = a + b; ovr flags a same-sign magnitude carry-out.
// Q only documents the binary point; the add is identical for any fractional split.
module qadd #(
  parameter int Q = 15,
  parameter int N = 32
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] c,
  output logic         ovr
);

  logic [N-1:0] mag_sum;

  always_comb begin
    c       = '0;
    ovr     = 1'b0;
    mag_sum = {1'b0, a[N-2:0]} + {1'b0, b[N-2:0]};
    if (a[N-1] == b[N-1]) begin
      c   = {a[N-1], mag_sum[N-2:0]};
      ovr = mag_sum[N-1];
    end else if (a[N-2:0] > b[N-2:0]) begin
      c = {a[N-1], a[N-2:0] - b[N-2:0]};
    end else begin
      c = {b[N-1], b[N-2:0] - a[N-2:0]};
    end
  end

  if (Q >= N - 1) begin : g_bad_q
    $error("qadd: Q must leave at least one integer bit");
  end

endmodule

// File: rtl/qadd_accum_seq.sv
// Accumulates LEN sign-magnitude terms onto a bias through one shared qadd; result after LEN+1 cycles.
// in_ready only in ACC (in_valid low stalls); result held in DONE until out_ready, saturating on overflow.
module qadd_accum_seq
  import qadd_pkg::*;
#(
  parameter int N   = QADD_N,
  parameter int Q   = QADD_Q,
  parameter int LEN = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] bias,
  input  logic         in_valid,
  input  logic [N-1:0] in_data,
  output logic         in_ready,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_sum,
  output logic         out_ovf,
  output logic         busy
);

  localparam int CW = $clog2(LEN + 1);

  state_t         state, state_nxt;
  logic [N-1:0]   acc;
  logic [CW-1:0]  cnt;
  logic           ovf;
  logic [N-1:0]   add_sum;
  logic           add_ovr;
  logic [N-1:0]   acc_nxt;
  logic           ovf_nxt;
  logic           last_beat;

  qadd #(.Q(Q), .N(N)) u_qadd (
    .a   (acc),
    .b   (in_data),
    .c   (add_sum),
    .ovr (add_ovr)
  );

  // Saturation keeps the accumulator's sign; later terms continue from the clamped value.
  assign acc_nxt   = add_ovr ? N'(sm_sat(acc[N-1], N)) : add_sum;
  assign ovf_nxt   = ovf | add_ovr;
  assign last_beat = (cnt == CW'(LEN - 1));

  assign in_ready  = (state == ACC);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = ACC;
      ACC:     if (in_valid && last_beat) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      acc     <= '0;
      cnt     <= '0;
      ovf     <= 1'b0;
      out_sum <= '0;
      out_ovf <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && start) begin
        acc <= bias;
        cnt <= '0;
        ovf <= 1'b0;
      end else if (state == ACC && in_valid) begin
        acc <= acc_nxt;
        cnt <= cnt + CW'(1);
        ovf <= ovf_nxt;
        if (last_beat) begin
          out_sum <= N'(sm_norm(64'(acc_nxt), N));
          out_ovf <= ovf_nxt;
        end
      end
    end
  end

  if (LEN < 1 || N > 64 || N < 2) begin : g_bad_cfg
    $error("qadd_accum_seq: need LEN >= 1 and 2 <= N <= 64");
  end

endmodule

// File: doc/qadd_accum_seq.md
Name: qadd_accum_seq

Overview:
Sequencer that time-shares one combinational sign-magnitude fixed-point adder (qadd) to accumulate a stream of LEN terms onto a bias. It produces one neuron pre-activation sum per job. It sits between the weighted-product stream and the CORDIC activation stage. Handshakes are valid/ready, and the result saturates on overflow.

Parameters:
N, 32, total word width; bit N-1 is the sign, bits N-2:0 are the magnitude.
Q, 15, fractional bits; passed through to qadd only, no effect on control.
LEN, 8, terms per job; must be >= 1.

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  begin a job; sampled only in IDLE
bias  in  N  sign-magnitude initial accumulator value; captured on the start edge
in_valid  in  1  term available
in_data  in  N  sign-magnitude term
in_ready  out  1  term accepted on an edge where in_valid & in_ready
out_valid  out  1  result available
out_ready  in  1  consumer accepts the result
out_sum  out  N  final sign-magnitude sum
out_ovf  out  1  sticky: saturation occurred at least once during the job
busy  out  1  high in any state except IDLE

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; acc=0, cnt=0, ovf=0.
  - Outputs in_ready=0, out_valid=0, out_sum=0, out_ovf=0, busy=0.
  - Reset mid-job discards all progress; no partial result is ever presented.
- States: IDLE -> ACC -> DONE -> IDLE.
- IDLE:
  - start=1: acc<=bias, cnt<=0, ovf<=0, go to ACC.
  - start=0: stay in IDLE.
  - in_valid is ignored in IDLE.
- ACC:
  - in_ready=1 combinationally.
  - On each accepting edge: acc<=sat(qadd(acc,in_data)), cnt<=cnt+1.
  - When the accepted beat has cnt==LEN-1, go to DONE.
  - in_valid=0 stalls indefinitely with no state change.
- Saturation: if qadd ovr=1 (same-sign magnitude carry-out), acc takes sign=acc sign, magnitude=all ones (0x7FFFFFFF for +, 0xFFFFFFFF for -), and ovf<=1. Later terms continue from the saturated value.
- DONE:
  - out_valid=1, in_ready=0.
  - out_sum is registered and stable while out_valid=1 and out_ready=0.
  - A zero-magnitude result is normalised to +0: -0 becomes 0x00000000.
  - out_ready=1: go to IDLE next edge; out_valid falls.
  - start is ignored in ACC and DONE. No overlapping of result hold with the next job.
- Latency with no stalls: start sampled at edge t0, terms accepted at t1..tLEN, out_valid high after tLEN. The first result is available LEN+1 cycles after start. Job throughput is LEN+2 cycles.
- cnt width is $clog2(LEN+1); cnt never wraps within a job.
- out_sum and out_ovf hold their last values in IDLE until the next DONE.

Decomposition:
- Package qadd_pkg holds:
  - default N/Q;
  - state enum {IDLE, ACC, DONE};
  - function sm_sat(sign) returning the saturated word;
  - function sm_norm(x) clearing the sign when the magnitude is 0.
- Sub-module: one instance of the existing qadd (a=acc, b=in_data); no other sub-modules. All state stays in qadd_accum_seq.

Test Plan:
- LEN=4, Q=15, bias=0x00008000 (+1.0), terms 0x00008000, 0x80004000, 0x00002000, 0x80010000 with in_valid held high -> out_valid exactly 5 cycles after start, out_sum=0x80002000 (-0.25), out_ovf=0.
- bias=0x7FFF0000, terms 0x00020000, 0, 0, 0 -> out_sum=0x7FFFFFFF, out_ovf=1. Repeat with bias=0xFFFF0000 and first term 0x80020000 -> out_sum=0xFFFFFFFF, out_ovf=1.
- Negative zero: bias=0x80000000, all terms 0x80000000 -> out_sum=0x00000000. Also bias=0x80008000, first term 0x00008000, rest 0 -> out_sum=0x00000000.
- Stall and backpressure:
  - Drop in_valid for 3 cycles between beats 2 and 3 -> cnt and acc frozen, result unchanged.
  - In DONE hold out_ready=0 for 5 cycles with start=1 pulsing -> out_sum stable, start ignored, busy=1.
  - Then out_ready=1 -> IDLE.
- Reset mid-job: after 2 accepted beats pull rst_n low asynchronously (mid-cycle) -> busy, in_ready, out_valid, out_sum all 0 immediately. A new job (bias=0, terms all 0x00000001) then yields 0x00000004 with no residue.
- Back-to-back jobs: start asserted in the cycle after the out_ready handshake -> second job runs normally; out_ovf from the first job (1) is cleared for the second (0).
